data_mem_responder: RTL and testbench

//  Responder end of the core's load/store bus: serves MEMPREP/MEMEX data requests from the LSU.

---
 rtl/data_bus_pkg.sv | 40 ++++
 rtl/data_ram.sv | 34 +++
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// ============================================================================
// Module : data_bus_pkg
// Brief  : Shared types and constants for the LSU data-bus responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package data_bus_pkg;

  typedef enum logic [1:0] {
    MEM_B   = 2'b00,
    MEM_H   = 2'b01,
    MEM_W   = 2'b10,
    MEM_ILL = 2'b11
  } mem_size_t;

  localparam logic [31:0] MMIO_SEG_OFS   = 32'd0;
  localparam logic [31:0] MMIO_CYCLE_OFS = 32'd4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

  // Operand must already be shifted so the selected lanes sit at the LSBs.
  function automatic logic [31:0] load_extend(input logic [31:0] v,
                                              input mem_size_t   size,
                                              input logic        uns);
    logic [31:0] r;
    case (size)
      MEM_B:   r = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      MEM_H:   r = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram.sv
// ============================================================================
// Module : data_ram
// Brief  : Single-port synchronous-read word RAM with per-byte write enables.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read-first: a write and read of the same word return the old contents.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module : data_mem_responder
// Brief  : LSU load/store responder: data RAM, SEG and CYCLE MMIO, in-order resp.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import data_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] seg_value
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] SEG_ADDR  = MMIO_BASE + MMIO_SEG_OFS;
  localparam logic [31:0] CYC_ADDR  = MMIO_BASE + MMIO_CYCLE_OFS;

  logic        ready_en;
  logic [1:0]  outstanding;
  logic [31:0] cycle_cnt, seg_q;

  logic        a_valid, a_we, a_unsigned;
  mem_size_t   a_size;
  logic [31:0] a_addr, a_wdata;

  logic        b_valid, b_err, b_load, b_from_mmio, b_unsigned;
  mem_size_t   b_size;
  logic [1:0]  b_lane;
  logic [31:0] b_mmio_data;

  mem_resp_t   fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_cnt;

  logic        accept, pop, push, b_stall, a_adv;
  logic        hit_ram, hit_seg, hit_cyc, a_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] wdata_rep, ram_rdata, b_shifted, b_result;
  mem_resp_t   head;

  assign req_ready = ready_en && (outstanding != 2'd3);
  assign accept    = req_valid && req_ready;
  assign pop       = resp_valid && resp_ready;
  // Stage B doubles as a third response slot: it holds when the FIFO is full.
  assign push      = b_valid && ((fifo_cnt != 2'd2) || pop);
  assign b_stall   = b_valid && !push;
  assign a_adv     = a_valid && !b_stall;

  always_comb begin
    hit_ram = a_addr < RAM_BYTES;
    hit_seg = a_addr[31:2] == SEG_ADDR[31:2];
    hit_cyc = a_addr[31:2] == CYC_ADDR[31:2];
    a_err   = (a_size == MEM_ILL)
            || ((a_size == MEM_H) && a_addr[0])
            || ((a_size == MEM_W) && (a_addr[1:0] != 2'b00))
            || !(hit_ram || hit_seg || hit_cyc)
            || ((hit_seg || hit_cyc) && (a_size != MEM_W))
            || (hit_cyc && a_we);
    ram_en  = a_adv && cpu_rst && hit_ram && !a_err;
    ram_we  = 4'b0000;
    wdata_rep = a_wdata;
    if (ram_en && a_we) begin
      case (a_size)
        MEM_B:   begin ram_we = 4'b0001 << a_addr[1:0]; wdata_rep = {4{a_wdata[7:0]}};  end
        MEM_H:   begin ram_we = 4'b0011 << a_addr[1:0]; wdata_rep = {2{a_wdata[15:0]}}; end
        default: ram_we = 4'b1111;
      endcase
    end
  end

  data_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (a_addr[AW+1:2]),
    .wdata (wdata_rep),
    .rdata (ram_rdata)
  );

  assign b_shifted = (b_from_mmio ? b_mmio_data : ram_rdata) >> {b_lane, 3'b000};
  assign b_result  = b_load ? load_extend(b_shifted, b_size, b_unsigned) : 32'd0;

  always_ff @(posedge clk) begin
    if (!cpu_rst) begin
      ready_en    <= 1'b0;
      outstanding <= 2'd0;
      cycle_cnt   <= 32'd0;
      seg_q       <= 32'd0;
      a_valid     <= 1'b0;
      b_valid     <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      ready_en  <= 1'b1;
      cycle_cnt <= cycle_cnt + 32'd1;

      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase

      if (accept) begin
        a_valid    <= 1'b1;
        a_we       <= req_we;
        a_size     <= mem_size_t'(req_size);
        a_unsigned <= req_unsigned;
        a_addr     <= req_addr;
        a_wdata    <= req_wdata;
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end

      if (a_adv) begin
        b_valid     <= 1'b1;
        b_err       <= a_err;
        b_load      <= !a_we && !a_err;
        b_from_mmio <= hit_seg || hit_cyc;
        b_mmio_data <= hit_cyc ? cycle_cnt : seg_q;
        b_lane      <= a_addr[1:0];
        b_size      <= a_size;
        b_unsigned  <= a_unsigned;
        if (a_we && !a_err && hit_seg) seg_q <= a_wdata;
      end else if (push) begin
        b_valid <= 1'b0;
      end

      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rdata: b_result, err: b_err};
  end

  assign head       = fifo_mem[rd_ptr];
  assign resp_valid = fifo_cnt != 2'd0;
  assign resp_rdata = resp_valid ? head.rdata : 32'd0;
  assign resp_err   = resp_valid && head.err;
  assign seg_value  = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module : tb_data_mem_responder
// Brief  : Scoreboard bench for data_mem_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] seg_value;

  localparam logic [31:0] SEG = 32'h0001_0000;
  localparam logic [31:0] CYC = 32'h0001_0004;

  data_mem_responder dut (
    .clk(clk), .cpu_rst(cpu_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .seg_value(seg_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   e0 = 0;
  bit   lat_chk = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (resp_valid && resp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp rdata=%h err=%b", resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          errors++;
          $display("FAIL resp_data got rdata=%h err=%b want rdata=%h err=%b",
                   resp_rdata, resp_err, e.rdata, e.err);
        end
        if (e.lat) begin
          checks++;
          if (cyc - e.acc !== 2) begin
            errors++;
            $display("FAIL resp_latency got %0d want 2", cyc - e.acc);
          end
        end
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input bit exp_cycle);
    bit done = 1'b0;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h got no accept want accept", addr);
    end else begin
      e.rdata = exp_cycle ? 32'(cyc + 1 - e0) : exp_rd;
      e.err   = exp_err;
      e.acc   = cyc;
      e.lat   = lat_chk;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid) done = 1'b1;
    end
    @(posedge clk); #1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    cpu_rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    checks++; if (seg_value !== 32'd0) begin errors++; $display("FAIL rst_seg got %h want 0", seg_value); end
    checks++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL rst_resp got %h/%b want 0/0", resp_rdata, resp_err);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; cpu_rst = 1'b1; e0 = cyc + 1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_sizing();
    send(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'd0, 0, 0);
    send(0, 2'b00, 0, 32'h13, 32'd0, 32'hFFFFFFDE, 0, 0);
    send(0, 2'b00, 1, 32'h13, 32'd0, 32'h000000DE, 0, 0);
    send(0, 2'b01, 0, 32'h12, 32'd0, 32'hFFFFDEAD, 0, 0);
    send(0, 2'b01, 1, 32'h10, 32'd0, 32'h0000BEEF, 0, 0);
    send(0, 2'b00, 1, 32'h10, 32'd0, 32'h000000EF, 0, 0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    send(1, 2'b00, 0, 32'h11, 32'h5A, 32'd0, 0, 0);
    send(0, 2'b10, 0, 32'h10, 32'd0, 32'hDEAD5AEF, 0, 0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++)
      send(1, 2'b10, 0, 32'h20 + 32'(4*i), 32'hA0A0_0000 + 32'(i), 32'd0, 0, 0);
    wait_drain();
    lat_chk = 1'b0; resp_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(0, 2'b10, 0, 32'h20 + 32'(4*i), 32'd0, 32'hA0A0_0000 + 32'(i), 0, 0);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h2C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL credit_block got %b want 0", req_ready); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    send(0, 2'b10, 0, 32'h2C, 32'd0, 32'hA0A0_0003, 0, 0);
    wait_drain();
    lat_chk = 1'b1;
  endtask

  task automatic test_errors();
    send(1, 2'b10, 0, 32'h0, 32'h0BADF00D, 32'd0, 0, 0);
    send(0, 2'b01, 0, 32'h1, 32'd0, 32'd0, 1, 0);
    send(0, 2'b10, 0, 32'h2, 32'd0, 32'd0, 1, 0);
    send(0, 2'b10, 0, 32'h1000, 32'd0, 32'd0, 1, 0);
    send(0, 2'b11, 0, 32'h0, 32'd0, 32'd0, 1, 0);
    send(1, 2'b10, 0, CYC, 32'h55, 32'd0, 1, 0);
    send(1, 2'b00, 0, SEG, 32'h77, 32'd0, 1, 0);
    send(1, 2'b11, 0, 32'h0, 32'hFFFFFFFF, 32'd0, 1, 0);
    send(1, 2'b01, 0, 32'h1, 32'hFFFF, 32'd0, 1, 0);
    send(1, 2'b10, 0, 32'h1000, 32'h1, 32'd0, 1, 0);
    send(0, 2'b10, 0, 32'h0, 32'd0, 32'h0BADF00D, 0, 0);
    wait_drain();
    checks++; if (seg_value !== 32'd0) begin errors++; $display("FAIL err_seg got %h want 0", seg_value); end
  endtask

  task automatic test_mmio_and_reset();
    send(1, 2'b10, 0, SEG, 32'h1234, 32'd0, 0, 0);
    send(0, 2'b10, 0, SEG, 32'd0, 32'h1234, 0, 0);
    send(0, 2'b10, 0, CYC, 32'd0, 32'd0, 0, 1);
    send(0, 2'b10, 0, CYC, 32'd0, 32'd0, 0, 1);
    wait_drain();
    checks++; if (seg_value !== 32'h1234) begin errors++; $display("FAIL seg_write got %h want 00001234", seg_value); end
    resp_ready = 1'b0;
    send(0, 2'b10, 0, 32'h10, 32'd0, 32'd0, 0, 0);
    send(0, 2'b10, 0, 32'h14, 32'd0, 32'd0, 0, 0);
    cpu_rst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk); #1;
    cpu_rst = 1'b1; e0 = cyc + 1; resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp_valid got %b want 0", resp_valid); end
    end
    checks++; if (seg_value !== 32'd0) begin errors++; $display("FAIL flush_seg got %h want 0", seg_value); end
    @(posedge clk); #1;
    send(0, 2'b10, 0, CYC, 32'd0, 32'd0, 0, 1);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_sizing();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_mmio_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
